// File: rtl/gb_ram_pkg.sv
// Shared types and helpers for the ghostbus host-accessible RAM.
package gb_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } gb_state_e;

    localparam int RD_LAT_MAX = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/gb_ram_sp_core.sv
// Register-array RAM: one write port, two read ports, each with a
// read-first output pipeline that carries zero data when not valid.
module gb_ram_sp_core
    import gb_ram_pkg::*;
#(
    parameter int MW     = 8,
    parameter int MD     = 64,
    parameter int RD_LAT = 1,
    parameter int IW     = clog2(MD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [MW-1:0] wdata,
    input  logic          a_re,
    input  logic          a_blank,
    input  logic [IW-1:0] a_addr,
    output logic [MW-1:0] a_rdata,
    output logic          a_rvalid,
    input  logic          b_re,
    input  logic [IW-1:0] b_addr,
    output logic [MW-1:0] b_rdata,
    output logic          b_rvalid
);

    localparam int LAT = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                         (RD_LAT < 1) ? 1 : RD_LAT;

    logic [MW-1:0] mem_q [MD];

    logic [LAT-1:0]         av_q, av_d, bv_q, bv_d;
    logic [LAT-1:0][MW-1:0] ad_q, ad_d, bd_q, bd_d;

    // Contents are deliberately left unreset; the fill sequencer seeds them.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    always_comb begin
        av_d    = '0;
        bv_d    = '0;
        ad_d    = '0;
        bd_d    = '0;
        av_d[0] = a_re;
        bv_d[0] = b_re;
        ad_d[0] = (a_re && !a_blank) ? mem_q[a_addr] : '0;
        bd_d[0] = b_re ? mem_q[b_addr] : '0;
        for (int i = 1; i < LAT; i++) begin
            av_d[i] = av_q[i-1];
            bv_d[i] = bv_q[i-1];
            ad_d[i] = ad_q[i-1];
            bd_d[i] = bd_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            av_q <= '0;
            bv_q <= '0;
            ad_q <= '0;
            bd_q <= '0;
        end else begin
            av_q <= av_d;
            bv_q <= bv_d;
            ad_q <= ad_d;
            bd_q <= bd_d;
        end
    end

    assign a_rvalid = av_q[LAT-1];
    assign a_rdata  = ad_q[LAT-1];
    assign b_rvalid = bv_q[LAT-1];
    assign b_rdata  = bd_q[LAT-1];

endmodule

// File: rtl/gb_ha_ram_ctrl.sv
// Ghostbus-decoded RAM with an arbitrated local port and a
// seed+index pattern fill sequencer.
module gb_ha_ram_ctrl
    import gb_ram_pkg::*;
#(
    parameter int            AW        = 24,
    parameter int            DW        = 32,
    parameter int            MW        = 8,
    parameter int            MD        = 64,
    parameter logic [AW-1:0] BASE      = 'h100,
    parameter int            RD_LAT    = 1,
    parameter int            AUTO_INIT = 1,
    parameter int            SEED      = 'h81,
    parameter int            STEP      = 1,
    parameter int            IW        = clog2(MD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] gb_addr,
    input  logic [DW-1:0] gb_wdata,
    input  logic          gb_we,
    input  logic          gb_re,
    output logic [DW-1:0] gb_rdata,
    output logic          gb_rvalid,
    input  logic [IW-1:0] loc_addr,
    input  logic [MW-1:0] loc_wdata,
    input  logic          loc_req,
    input  logic          loc_we,
    output logic          loc_ack,
    output logic [MW-1:0] loc_rdata,
    output logic          loc_rvalid,
    input  logic          init_start,
    output logic          init_busy,
    output logic          init_done
);

    gb_state_e     state_q, state_d;
    logic [IW-1:0] fill_q, fill_d;
    logic          auto_q, auto_d;

    logic [AW-1:0] off;
    logic [IW-1:0] idx;
    logic          host_hit;
    logic          filling;
    logic [MW-1:0] fill_val;
    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [MW-1:0] mem_wdata;
    logic [MW-1:0] host_rd;
    logic          unused_wdata;

    assign off      = gb_addr - BASE;
    assign host_hit = (gb_addr >= BASE) && (off < AW'(MD));
    assign idx      = off[IW-1:0];
    assign filling  = (state_q == ST_FILL);
    assign fill_val = MW'(SEED) + MW'(fill_q) * MW'(STEP);
    assign unused_wdata = ^gb_wdata;

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        auto_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (init_start || auto_q) begin
                    state_d = ST_FILL;
                    fill_d  = '0;
                end
            end
            ST_FILL: begin
                if (fill_q == IW'(MD - 1)) begin
                    state_d = ST_DONE;
                    fill_d  = '0;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            fill_q  <= '0;
            auto_q  <= (AUTO_INIT != 0);
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            auto_q  <= auto_d;
        end
    end

    assign loc_ack = loc_req && !host_hit && !filling;

    // Fill owns the write port; host writes are dropped while it runs.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = gb_wdata[MW-1:0];
        if (filling) begin
            mem_we    = 1'b1;
            mem_waddr = fill_q;
            mem_wdata = fill_val;
        end else if (host_hit && gb_we) begin
            mem_we = 1'b1;
        end else if (loc_ack && loc_we) begin
            mem_we    = 1'b1;
            mem_waddr = loc_addr;
            mem_wdata = loc_wdata;
        end
    end

    gb_ram_sp_core #(
        .MW     (MW),
        .MD     (MD),
        .RD_LAT (RD_LAT),
        .IW     (IW)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (mem_we),
        .waddr    (mem_waddr),
        .wdata    (mem_wdata),
        .a_re     (host_hit && gb_re),
        .a_blank  (filling),
        .a_addr   (idx),
        .a_rdata  (host_rd),
        .a_rvalid (gb_rvalid),
        .b_re     (loc_ack && !loc_we),
        .b_addr   (loc_addr),
        .b_rdata  (loc_rdata),
        .b_rvalid (loc_rvalid)
    );

    assign gb_rdata  = DW'(host_rd);
    assign init_busy = filling;
    assign init_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_gb_ha_ram_ctrl.sv
// Directed bench: default instance, a wide/deep variant, and a
// no-auto-init RD_LAT=2 variant, exercised one at a time.
module tb_gb_ha_ram_ctrl;

    logic        clk = 1'b0;
    logic [23:0] gb_addr;
    logic [31:0] gb_wdata;
    logic        gb_we, gb_re, init_start;
    logic        rst0, rst1, rst2;

    logic [31:0] r0_d, r1_d, r2_d;
    logic        r0_v, r1_v, r2_v;
    logic        busy0, busy1, busy2, done0, done1, done2;
    logic        lack0, lack1, lack2, lrv0, lrv1, lrv2;
    logic [7:0]  lrd0, lrd2;
    logic [15:0] lrd1;

    logic [5:0]  z_a6;
    logic [7:0]  z_d8, z_a8;
    logic [15:0] z_d16;
    logic        z_b;

    logic [5:0]  loc_addr;
    logic [7:0]  loc_wdata;
    logic        loc_req, loc_we;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic        re;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic        ev;
        logic [31:0] ed;
    } vec_t;

    vec_t vt[12];

    always #5 clk = ~clk;

    gb_ha_ram_ctrl u0 (
        .clk(clk), .rst_n(rst0),
        .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_we(gb_we), .gb_re(gb_re),
        .gb_rdata(r0_d), .gb_rvalid(r0_v),
        .loc_addr(z_a6), .loc_wdata(z_d8), .loc_req(z_b), .loc_we(z_b),
        .loc_ack(lack0), .loc_rdata(lrd0), .loc_rvalid(lrv0),
        .init_start(init_start), .init_busy(busy0), .init_done(done0)
    );

    gb_ha_ram_ctrl #(
        .MW(16), .MD(256), .SEED('h1000), .STEP(3)
    ) u1 (
        .clk(clk), .rst_n(rst1),
        .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_we(gb_we), .gb_re(gb_re),
        .gb_rdata(r1_d), .gb_rvalid(r1_v),
        .loc_addr(z_a8), .loc_wdata(z_d16), .loc_req(z_b), .loc_we(z_b),
        .loc_ack(lack1), .loc_rdata(lrd1), .loc_rvalid(lrv1),
        .init_start(init_start), .init_busy(busy1), .init_done(done1)
    );

    gb_ha_ram_ctrl #(
        .AUTO_INIT(0), .RD_LAT(2)
    ) u2 (
        .clk(clk), .rst_n(rst2),
        .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_we(gb_we), .gb_re(gb_re),
        .gb_rdata(r2_d), .gb_rvalid(r2_v),
        .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_req(loc_req),
        .loc_we(loc_we),
        .loc_ack(lack2), .loc_rdata(lrd2), .loc_rvalid(lrv2),
        .init_start(init_start), .init_busy(busy2), .init_done(done2)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_bus();
        gb_we      = 1'b0;
        gb_re      = 1'b0;
        gb_addr    = '0;
        gb_wdata   = '0;
        init_start = 1'b0;
    endtask

    initial begin
        int  busy_cnt, done_cnt, bad;
        logic got;

        vt[0]  = '{0, 1, 24'h100, 32'h0,        1, 32'h81};
        vt[1]  = '{0, 1, 24'h13F, 32'h0,        1, 32'hC0};
        vt[2]  = '{1, 0, 24'h105, 32'hDEADBEEF, 0, 32'h0};
        vt[3]  = '{0, 1, 24'h105, 32'h0,        1, 32'hEF};
        vt[4]  = '{0, 1, 24'h140, 32'h0,        0, 32'h0};
        vt[5]  = '{0, 1, 24'h0FF, 32'h0,        0, 32'h0};
        vt[6]  = '{1, 1, 24'h110, 32'h55,       1, 32'h91};
        vt[7]  = '{0, 1, 24'h110, 32'h0,        1, 32'h55};
        vt[8]  = '{1, 0, 24'h140, 32'h77,       0, 32'h0};
        vt[9]  = '{0, 1, 24'h100, 32'h0,        1, 32'h81};
        vt[10] = '{0, 1, 24'h101, 32'h0,        1, 32'h82};
        vt[11] = '{0, 0, 24'h000, 32'h0,        0, 32'h0};

        z_a6 = '0; z_d8 = '0; z_a8 = '0; z_d16 = '0; z_b = 1'b0;
        loc_addr = '0; loc_wdata = '0; loc_req = 1'b0; loc_we = 1'b0;
        idle_bus();
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        // u0: reset state, auto fill, then vector table
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", 32'(r0_v), 32'h0);
        chk("rst_rdata", r0_d, 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_done", 32'(done0), 32'h0);
        chk("rst_lrvalid", 32'(lrv0), 32'h0);

        @(negedge clk) rst0 = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            busy_cnt += int'(busy0);
            done_cnt += int'(done0);
        end
        chk("u0_busy_cycles", 32'(busy_cnt), 32'd64);
        chk("u0_done_pulses", 32'(done_cnt), 32'd1);

        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            gb_we    = vt[k].we;
            gb_re    = vt[k].re;
            gb_addr  = vt[k].addr;
            gb_wdata = vt[k].wdata;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_rvalid", k), 32'(r0_v), 32'(vt[k].ev));
            chk($sformatf("vec%0d_rdata", k), r0_d, vt[k].ed);
        end
        @(negedge clk);
        idle_bus();
        rst0 = 1'b0;

        // u1: MW=16 MD=256, refill while a host write is dropped
        @(negedge clk) rst1 = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (done1) got = 1'b1;
        end
        chk("u1_autofill_done", 32'(got), 32'h1);

        @(negedge clk);
        gb_re   = 1'b1;
        gb_addr = 24'h1FF;
        @(posedge clk);
        #1;
        chk("u1_rd255_valid", 32'(r1_v), 32'h1);
        chk("u1_rd255_data", r1_d, 32'h12FD);

        @(negedge clk);
        gb_re      = 1'b0;
        init_start = 1'b1;
        @(posedge clk);
        #1;
        chk("u1_restart_busy", 32'(busy1), 32'h1);

        @(negedge clk);
        init_start = 1'b0;
        gb_we      = 1'b1;
        gb_addr    = 24'h105;
        gb_wdata   = 32'hBEEF;
        @(negedge clk);
        gb_we   = 1'b0;
        gb_re   = 1'b1;
        gb_addr = 24'h1FF;
        @(posedge clk);
        #1;
        chk("u1_fillrd_valid", 32'(r1_v), 32'h1);
        chk("u1_fillrd_data", r1_d, 32'h0);

        @(negedge clk);
        idle_bus();
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (done1) got = 1'b1;
        end
        chk("u1_refill_done", 32'(got), 32'h1);

        @(negedge clk);
        gb_re   = 1'b1;
        gb_addr = 24'h105;
        @(posedge clk);
        #1;
        chk("u1_drop_wr", r1_d, 32'h100F);
        @(negedge clk);
        gb_addr = 24'h1FF;
        @(posedge clk);
        #1;
        chk("u1_refill_255", r1_d, 32'h12FD);
        @(negedge clk);
        idle_bus();
        rst1 = 1'b0;

        // u2: no auto fill, reset mid-fill, local port, RD_LAT=2
        @(negedge clk) rst2 = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bad += int'(busy2 | done2);
        end
        chk("u2_no_autofill", 32'(bad), 32'h0);

        @(negedge clk) init_start = 1'b1;
        @(posedge clk);
        @(negedge clk) init_start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("u2_busy_at20", 32'(busy2), 32'h1);
        rst2 = 1'b0;
        #1;
        chk("u2_abort_busy", 32'(busy2), 32'h0);
        @(negedge clk) rst2 = 1'b1;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            bad += int'(busy2 | done2);
        end
        chk("u2_no_restart", 32'(bad), 32'h0);

        @(negedge clk);
        gb_re   = 1'b1;
        gb_addr = 24'h113;
        @(posedge clk);
        #1;
        chk("u2_lat2_early", 32'(r2_v), 32'h0);
        @(negedge clk) gb_re = 1'b0;
        @(posedge clk);
        #1;
        chk("u2_lat2_valid", 32'(r2_v), 32'h1);
        chk("u2_idx19", r2_d, 32'h94);

        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            loc_req   = 1'b1;
            loc_we    = 1'b1;
            loc_addr  = 6'd3;
            loc_wdata = 8'h5A;
            gb_re     = 1'b1;
            gb_addr   = 24'h100 + 24'(h);
            #1;
            chk($sformatf("u2_blocked%0d", h), 32'(lack2), 32'h0);
        end
        @(negedge clk);
        idle_bus();
        #1;
        chk("u2_wr_ack", 32'(lack2), 32'h1);
        @(negedge clk);
        loc_we = 1'b0;
        #1;
        chk("u2_rd_ack", 32'(lack2), 32'h1);
        @(posedge clk);
        #1;
        chk("u2_lrv_early", 32'(lrv2), 32'h0);
        @(negedge clk) loc_req = 1'b0;
        @(posedge clk);
        #1;
        chk("u2_lrv", 32'(lrv2), 32'h1);
        chk("u2_lrd", 32'(lrd2), 32'h5A);

        @(negedge clk);
        gb_re   = 1'b1;
        gb_addr = 24'h100;
        @(posedge clk);
        @(negedge clk);
        gb_re = 1'b0;
        rst2  = 1'b0;
        @(posedge clk);
        #1;
        chk("u2_rst_drops_rd", 32'(r2_v), 32'h0);
        @(negedge clk) rst2 = 1'b1;
        @(posedge clk);
        #1;
        chk("u2_rd_stays_dropped", 32'(r2_v), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
